// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multicycle_controller_pkg : opcode, state and mux-select encodings
// Revision 1.0
// ----------------------------------------------------------------------------
package multicycle_controller_pkg;

  typedef enum logic [6:0] {
    rTypeInstruction  = 7'b0110011,
    iTypeInstruction  = 7'b0010011,
    loadInstruction   = 7'b0000011,
    storeInstruction  = 7'b0100011,
    branchInstruction = 7'b1100011,
    jalInstruction    = 7'b1101111,
    jalrInstruction   = 7'b1100111,
    luiInstruction    = 7'b0110111,
    auipcInstruction  = 7'b0010111
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_FAULT     = 3'd6
  } ctrl_state_t;

  typedef enum logic [1:0] {
    PC_SRC_PLUS4 = 2'd0,
    PC_SRC_ALU   = 2'd1,
    PC_SRC_JALR  = 2'd2
  } pc_src_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_t;

  typedef enum logic [1:0] {
    ALU_A_RS1   = 2'd0,
    ALU_A_OLDPC = 2'd1,
    ALU_A_ZERO  = 2'd2
  } alu_a_sel_t;

  // Rejects opcodes outside RV32I and the reserved branch/load/store funct3 codes.
  function automatic logic is_legal(input opcode_t op, input logic [2:0] f3);
    logic ok;
    case (op)
      rTypeInstruction, iTypeInstruction, jalInstruction, jalrInstruction,
      luiInstruction, auipcInstruction: ok = 1'b1;
      branchInstruction: ok = (f3 != 3'd2) && (f3 != 3'd3);
      loadInstruction:   ok = !((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7));
      storeInstruction:  ok = (f3 <= 3'd2);
      default:           ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_wait_timer : counts cycles a memory request waits; flags the last one
// Revision 1.0
// ----------------------------------------------------------------------------
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (MEM_TIMEOUT > 0) begin : g_timer
      localparam int CW = $clog2(MEM_TIMEOUT + 1);
      localparam logic [CW-1:0] C_LAST = CW'(MEM_TIMEOUT - 1);

      logic [CW-1:0] count_q;
      logic [CW-1:0] count_d;

      always_comb begin
        count_d = count_q;
        if (clr) begin
          count_d = '0;
        end else if (en) begin
          count_d = count_q + CW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          count_q <= '0;
        end else begin
          count_q <= count_d;
        end
      end

      // Asserted during the MEM_TIMEOUT-th consecutive waiting cycle.
      assign expired = en && (count_q == C_LAST);
    end else begin : g_no_timer
      assign expired = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multicycle_controller : RV32I multi-cycle control FSM
// Revision 1.0
// ----------------------------------------------------------------------------
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 16,
  parameter int RESET_PC_HOLD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  opcode_t     opcode,
  input  logic [2:0]  funct3,
  input  logic        branchTaken,
  input  logic        memReady,
  output logic        memReq,
  output logic        memWe,
  output logic        memAddrSel,
  output logic        irWrite,
  output logic        pcWrite,
  output logic [1:0]  pcSrc,
  output logic        regWrite,
  output logic [1:0]  wbSel,
  output logic [1:0]  aluASel,
  output logic        aluBSel,
  output logic        aluFunctEn,
  output logic [31:0] retired,
  output logic        fault
);

  localparam int HOLD_LAST = (RESET_PC_HOLD > 1) ? RESET_PC_HOLD - 1 : 0;
  localparam int HW        = (HOLD_LAST > 0) ? $clog2(HOLD_LAST + 1) : 1;
  localparam logic [HW-1:0] C_HOLD_LAST = HW'(HOLD_LAST);

  ctrl_state_t   state_q, state_d;
  opcode_t       opcode_q, opcode_d;
  logic [HW-1:0] idle_cnt_q, idle_cnt_d;
  logic [31:0]   retired_q, retired_d;
  logic          fault_q, fault_d;
  logic          retire;
  logic          timer_en;
  logic          timer_expired;

  // The counter runs only while a request is outstanding and unanswered.
  assign timer_en = ((state_q == S_FETCH) || (state_q == S_MEMORY)) && !memReady && !rst;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (!timer_en),
    .en     (timer_en),
    .expired(timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    idle_cnt_d = idle_cnt_q;
    memReq     = 1'b0;
    memWe      = 1'b0;
    memAddrSel = 1'b0;
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    pcSrc      = PC_SRC_PLUS4;
    regWrite   = 1'b0;
    wbSel      = WB_ALU;
    aluASel    = ALU_A_RS1;
    aluBSel    = 1'b0;
    aluFunctEn = 1'b0;
    retire     = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (idle_cnt_q == C_HOLD_LAST) state_d = S_FETCH;
          else                           idle_cnt_d = idle_cnt_q + HW'(1);
        end
        S_FETCH: begin
          memReq = 1'b1;
          if (memReady) begin
            irWrite = 1'b1;
            state_d = S_DECODE;
          end else if (timer_expired) begin
            state_d = S_FAULT;
          end
        end
        S_DECODE: begin
          opcode_d = opcode;
          state_d  = is_legal(opcode, funct3) ? S_EXECUTE : S_FAULT;
        end
        S_EXECUTE: begin
          state_d = S_WRITEBACK;
          case (opcode_q)
            rTypeInstruction: aluFunctEn = 1'b1;
            iTypeInstruction: begin
              aluBSel    = 1'b1;
              aluFunctEn = 1'b1;
            end
            loadInstruction, storeInstruction: begin
              aluBSel = 1'b1;
              state_d = S_MEMORY;
            end
            branchInstruction: begin
              aluASel = ALU_A_OLDPC;
              aluBSel = 1'b1;
              pcWrite = 1'b1;
              pcSrc   = branchTaken ? PC_SRC_ALU : PC_SRC_PLUS4;
              retire  = 1'b1;
              state_d = S_FETCH;
            end
            jalInstruction, auipcInstruction: begin
              aluASel = ALU_A_OLDPC;
              aluBSel = 1'b1;
            end
            jalrInstruction: aluBSel = 1'b1;
            default: ;
          endcase
        end
        S_MEMORY: begin
          memReq     = 1'b1;
          memAddrSel = 1'b1;
          memWe      = (opcode_q == storeInstruction);
          if (memReady) begin
            if (opcode_q == storeInstruction) begin
              pcWrite = 1'b1;
              retire  = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WRITEBACK;
            end
          end else if (timer_expired) begin
            state_d = S_FAULT;
          end
        end
        S_WRITEBACK: begin
          regWrite = 1'b1;
          pcWrite  = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
          case (opcode_q)
            loadInstruction: wbSel = WB_MEM;
            jalInstruction: begin
              wbSel = WB_PC4;
              pcSrc = PC_SRC_ALU;
            end
            jalrInstruction: begin
              wbSel = WB_PC4;
              pcSrc = PC_SRC_JALR;
            end
            luiInstruction: wbSel = WB_IMM;
            default: ;
          endcase
        end
        S_FAULT: ;
        default: state_d = S_FAULT;
      endcase
    end
    retired_d = retired_q + {31'd0, retire};
    fault_d   = fault_q | (state_d == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      opcode_q   <= rTypeInstruction;
      idle_cnt_q <= '0;
      retired_q  <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      idle_cnt_q <= idle_cnt_d;
      retired_q  <= retired_d;
      fault_q    <= fault_d;
    end
  end

  assign retired = retired_q;
  assign fault   = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_multicycle_controller : directed self-checking bench for the control FSM
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  logic        clk;
  logic        rst;
  opcode_t     opcode;
  logic [2:0]  funct3;
  logic        branchTaken;
  logic        memReady;
  logic        memReq, memWe, memAddrSel, irWrite, pcWrite, regWrite, aluBSel, aluFunctEn;
  logic [1:0]  pcSrc, wbSel, aluASel;
  logic [31:0] retired;
  logic        fault;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  logic [31:0] exp_ret   = 32'd0;

  // {memReq, memWe, memAddrSel, irWrite, pcWrite, pcSrc, regWrite, wbSel, aluASel, aluBSel, aluFunctEn}
  logic [13:0] outs;
  assign outs = {memReq, memWe, memAddrSel, irWrite, pcWrite, pcSrc, regWrite,
                 wbSel, aluASel, aluBSel, aluFunctEn};

  localparam logic [13:0] V_ZERO       = 14'd0;
  localparam logic [13:0] V_FETCH_RDY  = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
  localparam logic [13:0] V_FETCH_NRDY = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
  localparam logic [13:0] V_EX_R       = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1};
  localparam logic [13:0] V_EX_LS      = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0};
  localparam logic [13:0] V_EX_BT      = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0};
  localparam logic [13:0] V_EX_BNT     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0};
  localparam logic [13:0] V_EX_JALR    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0};
  localparam logic [13:0] V_MEM_LD     = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
  localparam logic [13:0] V_MEM_ST_RDY = {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
  localparam logic [13:0] V_WB_R       = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0};
  localparam logic [13:0] V_WB_LD      = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0};
  localparam logic [13:0] V_WB_JALR    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0};

  multicycle_controller #(
    .MEM_TIMEOUT  (16),
    .RESET_PC_HOLD(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct3     (funct3),
    .branchTaken(branchTaken),
    .memReady   (memReady),
    .memReq     (memReq),
    .memWe      (memWe),
    .memAddrSel (memAddrSel),
    .irWrite    (irWrite),
    .pcWrite    (pcWrite),
    .pcSrc      (pcSrc),
    .regWrite   (regWrite),
    .wbSel      (wbSel),
    .aluASel    (aluASel),
    .aluBSel    (aluBSel),
    .aluFunctEn (aluFunctEn),
    .retired    (retired),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the DUT in its first FETCH cycle, just after a falling edge.
  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_ret = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    memReady = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total_cnt++;
    if (outs !== V_ZERO) $display("FAIL reset_outs: got %h expected %h", outs, V_ZERO);
    else pass_cnt++;
    total_cnt++;
    if (retired !== 32'd0) $display("FAIL reset_retired: got %h expected 0", retired);
    else pass_cnt++;
    total_cnt++;
    if (fault !== 1'b0) $display("FAIL reset_fault: got %b expected 0", fault);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (outs !== V_ZERO) $display("FAIL idle_hold: got %h expected %h", outs, V_ZERO);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (outs !== V_FETCH_NRDY) $display("FAIL first_fetch: got %h expected %h", outs, V_FETCH_NRDY);
    else pass_cnt++;
    exp_ret = 32'd0;
  endtask

  task automatic test_rtype();
    logic [13:0] exp_v [4];
    exp_v = '{V_FETCH_RDY, V_ZERO, V_EX_R, V_WB_R};
    opcode = rTypeInstruction; funct3 = 3'd0; memReady = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      total_cnt++;
      if (outs !== exp_v[c]) $display("FAIL rtype_c%0d: got %h expected %h", c + 1, outs, exp_v[c]);
      else pass_cnt++;
      @(negedge clk);
    end
    exp_ret = exp_ret + 32'd1;
    #1;
    total_cnt++;
    if (retired !== exp_ret) $display("FAIL rtype_retired: got %h expected %h", retired, exp_ret);
    else pass_cnt++;
  endtask

  task automatic test_load();
    logic [13:0] exp_v [8];
    logic        rdy   [8];
    exp_v = '{V_FETCH_RDY, V_ZERO, V_EX_LS, V_MEM_LD, V_MEM_LD, V_MEM_LD, V_MEM_LD, V_WB_LD};
    rdy   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = loadInstruction; funct3 = 3'd2;
    for (int c = 0; c < 8; c++) begin
      memReady = rdy[c];
      #1;
      total_cnt++;
      if (outs !== exp_v[c]) $display("FAIL load_c%0d: got %h expected %h", c + 1, outs, exp_v[c]);
      else pass_cnt++;
      @(negedge clk);
    end
    exp_ret = exp_ret + 32'd1;
    #1;
    total_cnt++;
    if (retired !== exp_ret) $display("FAIL load_retired: got %h expected %h", retired, exp_ret);
    else pass_cnt++;
  endtask

  task automatic test_branch();
    logic [13:0] exp_v [3];
    opcode = branchInstruction; funct3 = 3'd0; memReady = 1'b1;
    for (int t = 0; t < 2; t++) begin
      branchTaken = (t == 0);
      exp_v = '{V_FETCH_RDY, V_ZERO, (t == 0) ? V_EX_BT : V_EX_BNT};
      for (int c = 0; c < 3; c++) begin
        #1;
        total_cnt++;
        if (outs !== exp_v[c]) $display("FAIL branch%0d_c%0d: got %h expected %h", t, c + 1, outs, exp_v[c]);
        else pass_cnt++;
        @(negedge clk);
      end
      exp_ret = exp_ret + 32'd1;
      #1;
      total_cnt++;
      if ((retired !== exp_ret) || (outs !== V_FETCH_RDY))
        $display("FAIL branch%0d_done: retired %h outs %h expected %h / %h", t, retired, outs, exp_ret, V_FETCH_RDY);
      else pass_cnt++;
    end
    branchTaken = 1'b0;
  endtask

  task automatic test_jalr();
    logic [13:0] exp_v [4];
    exp_v = '{V_FETCH_RDY, V_ZERO, V_EX_JALR, V_WB_JALR};
    opcode = jalrInstruction; funct3 = 3'd0; memReady = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      total_cnt++;
      if (outs !== exp_v[c]) $display("FAIL jalr_c%0d: got %h expected %h", c + 1, outs, exp_v[c]);
      else pass_cnt++;
      @(negedge clk);
    end
    exp_ret = exp_ret + 32'd1;
  endtask

  task automatic test_store();
    logic [13:0] exp_v [4];
    exp_v = '{V_FETCH_RDY, V_ZERO, V_EX_LS, V_MEM_ST_RDY};
    opcode = storeInstruction; funct3 = 3'd2; memReady = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      total_cnt++;
      if (outs !== exp_v[c]) $display("FAIL store_c%0d: got %h expected %h", c + 1, outs, exp_v[c]);
      else pass_cnt++;
      @(negedge clk);
    end
    exp_ret = exp_ret + 32'd1;
    #1;
    total_cnt++;
    if (retired !== exp_ret) $display("FAIL store_retired: got %h expected %h", retired, exp_ret);
    else pass_cnt++;
  endtask

  task automatic test_illegal_opcode();
    opcode = opcode_t'(7'h7F); funct3 = 3'd0; memReady = 1'b1;
    #1;
    total_cnt++;
    if (outs !== V_FETCH_RDY) $display("FAIL illop_fetch: got %h expected %h", outs, V_FETCH_RDY);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      memReady = c[0];
      branchTaken = 1'b1;
      #1;
      total_cnt++;
      if ((fault !== 1'b1) || (outs !== V_ZERO))
        $display("FAIL illop_fault_c%0d: fault %b outs %h expected 1 / %h", c, fault, outs, V_ZERO);
      else pass_cnt++;
      @(negedge clk);
    end
    branchTaken = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    total_cnt++;
    if ((fault !== 1'b0) || (retired !== 32'd0) || (outs !== V_ZERO))
      $display("FAIL illop_rst: fault %b retired %h outs %h expected 0 / 0 / 0", fault, retired, outs);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    exp_ret = 32'd0;
  endtask

  task automatic test_illegal_funct3();
    opcode = storeInstruction; funct3 = 3'd3; memReady = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total_cnt++;
    if ((fault !== 1'b1) || (outs !== V_ZERO))
      $display("FAIL st_funct3_fault: fault %b outs %h expected 1 / %h", fault, outs, V_ZERO);
    else pass_cnt++;
    apply_reset();
    #1;
    total_cnt++;
    if ((fault !== 1'b0) || (outs !== V_FETCH_RDY))
      $display("FAIL st_funct3_rst: fault %b outs %h expected 0 / %h", fault, outs, V_FETCH_RDY);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    memReady = 1'b0;
    for (int c = 0; c < 16; c++) begin
      #1;
      total_cnt++;
      if ((outs !== V_FETCH_NRDY) || (fault !== 1'b0))
        $display("FAIL timeout_wait_c%0d: outs %h fault %b expected %h / 0", c + 1, outs, fault, V_FETCH_NRDY);
      else pass_cnt++;
      @(negedge clk);
    end
    memReady = 1'b1;
    #1;
    total_cnt++;
    if ((fault !== 1'b1) || (outs !== V_ZERO))
      $display("FAIL timeout_fault: fault %b outs %h expected 1 / %h", fault, outs, V_ZERO);
    else pass_cnt++;
    apply_reset();
    #1;
    total_cnt++;
    if (fault !== 1'b0) $display("FAIL timeout_rst: got %b expected 0", fault);
    else pass_cnt++;
  endtask

  task automatic test_retired_wrap();
    memReady = 1'b0;
    force dut.retired_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.retired_q;
    exp_ret = 32'hFFFF_FFFF;
    opcode = rTypeInstruction; funct3 = 3'd0; memReady = 1'b1;
    repeat (4) @(negedge clk);
    exp_ret = exp_ret + 32'd1;
    #1;
    total_cnt++;
    if ((retired !== exp_ret) || (outs !== V_FETCH_RDY))
      $display("FAIL retired_wrap: retired %h outs %h expected %h / %h", retired, outs, exp_ret, V_FETCH_RDY);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    opcode = rTypeInstruction;
    funct3 = 3'd0;
    branchTaken = 1'b0;
    memReady = 1'b0;
    @(negedge clk);
    test_reset();
    test_rtype();
    test_load();
    test_branch();
    test_jalr();
    test_store();
    test_illegal_opcode();
    test_illegal_funct3();
    test_timeout();
    test_retired_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM that sequences the RV32I multi-cycle datapath around `decoder`: fetch, decode, execute, memory, writeback.
- Consumes the decoder's `opcode_t opcode` and `funct3`, plus a branch-compare result and a memory ready handshake.
- Drives all datapath enables and mux selects, a memory request, a retired-instruction counter and a sticky fault flag.
- Sits between the instruction/data memory port and the register file/ALU/PC registers.

Parameters:
- MEM_TIMEOUT, 16, max cycles `memReq` may wait for `memReady` before FAULT; 0 disables the timeout.
- RESET_PC_HOLD, 1, cycles held in IDLE after reset release before the first FETCH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  opcode_t  decoded major opcode from `decoder` (enumTypes.svh).
- funct3  in  3  decoded funct3; only used to flag illegal branch/load/store variants.
- branchTaken  in  1  comparator result for the current B-type instruction.
- memReady  in  1  memory has completed the current request (read data valid or write accepted).
- memReq  out  1  memory request; held high until `memReady`.
- memWe  out  1  request is a write.
- memAddrSel  out  1  0=PC, 1=ALU result.
- irWrite  out  1  latch the fetched instruction into IR and the old PC.
- pcWrite  out  1  update PC.
- pcSrc  out  2  0=PC+4, 1=ALU target, 2=ALU target & ~1 (JALR).
- regWrite  out  1  register-file write enable.
- wbSel  out  2  0=ALU, 1=memory data, 2=oldPC+4, 3=immediate.
- aluASel  out  2  0=rs1, 1=oldPC, 2=zero.
- aluBSel  out  1  0=rs2, 1=immediate.
- aluFunctEn  out  1  1=ALU decodes funct3/funct7; 0=forced ADD.
- retired  out  32  count of completed instructions; wraps.
- fault  out  1  sticky; set on illegal opcode or memory timeout.

Behaviour:
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, FAULT.
- Outputs are a Moore decode of the state plus a latched opcode. All outputs are 0 outside the states listed below.
- Reset: state=IDLE, retired=0, fault=0, every output 0. A reset asserted in any state, including mid memory request, aborts the instruction with no further writes.
- IDLE: waits RESET_PC_HOLD cycles, then goes to FETCH.
- FETCH: memReq=1, memAddrSel=0, memWe=0.
  - On memReady: irWrite=1 in the same cycle, then go to DECODE.
- DECODE: one cycle; captures opcode.
  - Illegal opcode, branch funct3 2/3, load funct3 3/6/7, or store funct3 >2: go to FAULT.
  - Otherwise go to EXECUTE.
- EXECUTE: one cycle.
  - R-type: aluA=rs1, aluB=rs2, aluFunctEn=1.
  - I-type: aluA=rs1, aluB=imm, aluFunctEn=1.
  - Load/store: aluA=rs1, aluB=imm, ADD; then go to MEMORY.
  - Branch: aluA=oldPC, aluB=imm, ADD; pcWrite=branchTaken, pcSrc=1. If not taken: pcWrite=1, pcSrc=0. Retire, then go to FETCH.
  - JAL: aluA=oldPC, aluB=imm. JALR: aluA=rs1, aluB=imm.
  - AUIPC: aluA=oldPC, aluB=imm. LUI: no ALU use.
  - All cases not listed above go to WRITEBACK.
- MEMORY: memReq=1, memAddrSel=1, memWe=1 for store. On memReady:
  - Store: pcWrite=1, pcSrc=0, retire, go to FETCH.
  - Load: go to WRITEBACK.
- WRITEBACK: regWrite=1, retire, go to FETCH.
  - wbSel: load=1, JAL/JALR=2, LUI=3, otherwise 0.
  - PC update: pcWrite=1. pcSrc=1 for JAL, 2 for JALR, otherwise 0.
- Cycle counts with memReady in the same cycle as the request:
  - R/I/LUI/AUIPC/JAL/JALR: 4.
  - Branch: 3.
  - Store: 4.
  - Load: 5.
- Timeout: a counter clears on entry to FETCH or MEMORY and increments each cycle memReq=1 without memReady. When it reaches MEM_TIMEOUT, go to FAULT.
- FAULT: fault=1, every enable 0; left only by rst.
- retired: increments by 1 on each retire cycle; 0xFFFFFFFF wraps to 0.

Decomposition:
- Add `ctrl_state_t` and the pcSrc/wbSel/aluASel encodings as typedef enums in enumTypes.svh, beside `opcode_t`.
- One sub-module, `mem_wait_timer`: the timeout counter, with clear/enable inputs and an expired output.

Test Plan:
- Reset, then opcode=rTypeInstruction with memReady tied 1: FETCH/DECODE/EXECUTE/WRITEBACK in 4 cycles. regWrite=1, wbSel=0 in cycle 4; retired=1.
- Load with memReady low for 3 cycles in MEMORY: memReq held for those 3 cycles. Instruction retires on cycle 8; wbSel=1 at writeback.
- Branch with branchTaken=1, then again with branchTaken=0: pcWrite=1 with pcSrc=1, then pcWrite=1 with pcSrc=0. Each takes 3 cycles; no regWrite.
- JALR: WRITEBACK shows pcSrc=2, wbSel=2, regWrite=1.
- Illegal opcode (for example 7'h7F via an out-of-enum value), and separately memReady stuck 0 for 16 cycles in FETCH: fault=1 and all enables 0 until rst. Asserting rst clears fault, retired=0, state=IDLE.
- Preload retired=0xFFFFFFFF by force, then retire one instruction: retired=0.
